// File: rtl/bram_log_ctrl_if.sv
// Bus between the log controller (master) and the single-port BRAM (slave).
//   o_bram_addr     word address
//   o_chipselect_n  active-low chip select
//   o_write_n       active-low write strobe (qualified by chip select)
//   o_read_n        active-low read strobe (qualified by chip select)
//   o_bram_data_in  write data
//   i_bram_data_out read data, one cycle after a read strobe, held otherwise
interface bram_log_ctrl_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] o_bram_addr;
  logic                  o_chipselect_n;
  logic                  o_write_n;
  logic                  o_read_n;
  logic [DATA_WIDTH-1:0] o_bram_data_in;
  logic [DATA_WIDTH-1:0] i_bram_data_out;

  modport master (
    output o_bram_addr, o_chipselect_n, o_write_n, o_read_n, o_bram_data_in,
    input  i_bram_data_out
  );

  modport slave (
    input  o_bram_addr, o_chipselect_n, o_write_n, o_read_n, o_bram_data_in,
    output i_bram_data_out
  );
endinterface

// File: rtl/bram_log_ctrl.sv
// Sample logger in front of a single-port BRAM.
// Captures valid samples from address 0 upward until the BRAM is full or a
// stop pulse arrives, then streams the stored words out over valid/ready.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_log_start / i_log_stop   start a capture at address 0 / end it early
//   i_sample, i_sample_valid   sample stream (no backpressure)
//   i_rd_start                 start readout from address 0
//   o_rd_data, o_rd_valid,
//   i_rd_ready                 readout stream (o_rd_data is 0 when not valid)
//   o_busy                     controller not idle
//   o_full, o_log_count        result of the last capture
//   bram                       BRAM bus (master side)
module bram_log_ctrl #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_log_start,
  input  logic                       i_log_stop,
  input  logic [BRAM_DATA_WIDTH-1:0] i_sample,
  input  logic                       i_sample_valid,
  input  logic                       i_rd_start,
  output logic [BRAM_DATA_WIDTH-1:0] o_rd_data,
  output logic                       o_rd_valid,
  input  logic                       i_rd_ready,
  output logic                       o_busy,
  output logic                       o_full,
  output logic [BRAM_ADDR_WIDTH:0]   o_log_count,
  bram_log_ctrl_if.master            bram
);

  localparam int CNT_W = BRAM_ADDR_WIDTH + 1;
  localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE  = 1;
  localparam logic [CNT_W-1:0]           CNT_ONE   = 1;

  typedef enum logic [1:0] {IDLE, LOG, RD_ISSUE, RD_DATA} state_t;

  state_t                     state;
  logic [BRAM_ADDR_WIDTH-1:0] wr_ptr;
  logic [BRAM_ADDR_WIDTH-1:0] rd_ptr;

  // NOTE: every register here is updated with <= so all branches see the
  // values from before the edge; mixing in blocking assignments would make
  // the result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      o_log_count         <= '0;
      o_full              <= 1'b0;
      o_busy              <= 1'b0;
      o_rd_valid          <= 1'b0;
      bram.o_chipselect_n <= 1'b1;
      bram.o_write_n      <= 1'b1;
      bram.o_read_n       <= 1'b1;
      bram.o_bram_addr    <= '0;
      bram.o_bram_data_in <= '0;
    end else begin
      // Strobes are single-cycle: released unless a branch below re-issues them.
      bram.o_chipselect_n <= 1'b1;
      bram.o_write_n      <= 1'b1;
      bram.o_read_n       <= 1'b1;

      case (state)
        IDLE: begin
          if (i_log_start) begin
            wr_ptr      <= '0;
            o_log_count <= '0;
            o_full      <= 1'b0;
            o_busy      <= 1'b1;
            state       <= LOG;
          end else if (i_rd_start && (o_log_count != '0)) begin
            // Issue the first read on the transition so the strobe is
            // visible during the RD_ISSUE cycle itself.
            rd_ptr              <= '0;
            bram.o_chipselect_n <= 1'b0;
            bram.o_read_n       <= 1'b0;
            bram.o_bram_addr    <= '0;
            o_busy              <= 1'b1;
            state               <= RD_ISSUE;
          end
        end

        LOG: begin
          if (i_sample_valid) begin
            bram.o_chipselect_n <= 1'b0;
            bram.o_write_n      <= 1'b0;
            bram.o_bram_addr    <= wr_ptr;
            bram.o_bram_data_in <= i_sample;
            o_log_count         <= o_log_count + CNT_ONE;
            if (wr_ptr == LAST_ADDR) begin
              // Last word: stop here rather than wrap onto address 0.
              o_full <= 1'b1;
              o_busy <= 1'b0;
              state  <= IDLE;
            end else begin
              wr_ptr <= wr_ptr + ADDR_ONE;
            end
          end
          if (i_log_stop) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end

        RD_ISSUE: begin
          // The BRAM registers its output at the end of this cycle.
          o_rd_valid <= 1'b1;
          state      <= RD_DATA;
        end

        RD_DATA: begin
          if (i_rd_ready) begin
            o_rd_valid <= 1'b0;
            if ({1'b0, rd_ptr} == (o_log_count - CNT_ONE)) begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end else begin
              rd_ptr              <= rd_ptr + ADDR_ONE;
              bram.o_chipselect_n <= 1'b0;
              bram.o_read_n       <= 1'b0;
              bram.o_bram_addr    <= rd_ptr + ADDR_ONE;
              state               <= RD_ISSUE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // The BRAM output register holds while no read is issued, so the word
  // stays stable for as long as the consumer stalls.
  assign o_rd_data = o_rd_valid ? bram.i_bram_data_out : '0;

endmodule
